// File: rtl/ws_exc_commit.sv
// Writeback-stage commit unit: resolves interrupts, upstream exceptions, ERET and
// MTC0 for the instruction leaving MEM, drives CP0 strobes and drains wrong-path work.
module ws_exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [4:0]  EX_INT     = 5'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_valid,
  output logic        ms_ready,
  input  logic [31:0] ms_pc,
  input  logic        ms_bd,
  input  logic        ms_ex,
  input  logic [4:0]  ms_excode,
  input  logic [31:0] ms_badvaddr,
  input  logic        ms_eret,
  input  logic        ms_mtc0,
  input  logic [4:0]  ms_cp0_addr,
  input  logic [31:0] ms_cp0_wdata,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic        fs_refetch_ack,
  output logic        cp0_ex_t,
  output logic [4:0]  cp0_excode_t,
  output logic        cp0_bd,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        eret_flush,
  output logic        cp0_we,
  output logic [4:0]  cp0_addr,
  output logic [31:0] cp0_wdata,
  output logic        ws_flush,
  output logic [31:0] inst_retired,
  output logic        fsm_state
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state;
  logic        ws_valid;
  logic        ws_bd;
  logic        ws_ex;
  logic        ws_eret;
  logic        ws_mtc0;
  logic [4:0]  ws_excode;
  logic [4:0]  ws_addr;
  logic [31:0] ws_pc;
  logic [31:0] ws_badvaddr;
  logic [31:0] ws_wdata;
  logic [31:0] retired_q;
  logic        int_req_r;
  logic        int_req_d;
  logic        take_int;
  logic        take_ex;
  logic        take_eret;
  logic        take_normal;
  logic        accept;
  logic        unused_bits;

  // Handshake: a transfer happens on every cycle with ms_valid=1 (ms_ready is tied
  // high); whether it is kept or discarded is decided here, never pushed back upstream.
  assign ms_ready = 1'b1;

  assign int_req_d = cp0_status[0] & ~cp0_status[1] & (|(cp0_cause[15:8] & cp0_status[15:8]));

  always_comb begin
    take_int    = ws_valid & int_req_r;
    take_ex     = ws_valid & ~int_req_r & ws_ex;
    take_eret   = ws_valid & ~int_req_r & ~ws_ex & ws_eret;
    take_normal = ws_valid & ~int_req_r & ~ws_ex & ~ws_eret;
  end

  assign cp0_ex_t     = take_int | take_ex;
  assign cp0_excode_t = take_int ? EX_INT : ws_excode;
  assign eret_flush   = take_eret;
  assign cp0_we       = take_normal & ws_mtc0;
  assign ws_flush     = cp0_ex_t | eret_flush;

  assign cp0_pc       = ws_pc;
  assign cp0_bd       = ws_bd;
  assign cp0_badvaddr = ws_badvaddr;
  assign cp0_addr     = ws_addr;
  assign cp0_wdata    = ws_wdata;
  assign inst_retired = retired_q;
  assign fsm_state    = (state == DRAIN);

  // The instruction sitting in MEM during a flush cycle is itself wrong-path.
  assign accept = ms_valid & (state == RUN) & ~ws_flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (ws_flush) state <= DRAIN;
        DRAIN:   if (fs_refetch_ack) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid    <= 1'b0;
      ws_bd       <= 1'b0;
      ws_ex       <= 1'b0;
      ws_eret     <= 1'b0;
      ws_mtc0     <= 1'b0;
      ws_excode   <= 5'd0;
      ws_addr     <= 5'd0;
      ws_pc       <= 32'd0;
      ws_badvaddr <= 32'd0;
      ws_wdata    <= 32'd0;
      retired_q   <= 32'd0;
      int_req_r   <= 1'b0;
    end else begin
      int_req_r <= int_req_d;
      ws_valid  <= accept;
      if (accept) begin
        ws_bd       <= ms_bd;
        ws_ex       <= ms_ex;
        ws_eret     <= ms_eret;
        ws_mtc0     <= ms_mtc0;
        ws_excode   <= ms_excode;
        ws_addr     <= ms_cp0_addr;
        ws_pc       <= ms_pc;
        ws_badvaddr <= ms_badvaddr;
        ws_wdata    <= ms_cp0_wdata;
      end
      if (take_normal) retired_q <= retired_q + 32'd1;
    end
  end

  assign unused_bits = ^{EXC_VECTOR, cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

endmodule

// File: tb/tb_ws_exc_commit.sv
// Bench for ws_exc_commit: directed scenarios plus a randomized stream checked
// against an instruction-level reference model.
module tb_ws_exc_commit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_valid, ms_ready, ms_bd, ms_ex, ms_eret, ms_mtc0;
  logic [31:0] ms_pc, ms_badvaddr, ms_cp0_wdata, cp0_status, cp0_cause;
  logic [4:0]  ms_excode, ms_cp0_addr;
  logic        fs_refetch_ack;
  logic        cp0_ex_t, cp0_bd, eret_flush, cp0_we, ws_flush, fsm_state;
  logic [4:0]  cp0_excode_t, cp0_addr;
  logic [31:0] cp0_pc, cp0_badvaddr, cp0_wdata, inst_retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } instr_t;

  // Reference model: what sits in writeback, whether we are discarding, interrupt sample, count.
  instr_t      m_ws;
  logic        m_valid = 1'b0;
  logic        m_drain = 1'b0;
  logic        m_int = 1'b0;
  logic [31:0] m_ret = 32'd0;

  ws_exc_commit dut (
    .clk(clk), .resetn(resetn), .ms_valid(ms_valid), .ms_ready(ms_ready),
    .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex), .ms_excode(ms_excode),
    .ms_badvaddr(ms_badvaddr), .ms_eret(ms_eret), .ms_mtc0(ms_mtc0),
    .ms_cp0_addr(ms_cp0_addr), .ms_cp0_wdata(ms_cp0_wdata),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .fs_refetch_ack(fs_refetch_ack),
    .cp0_ex_t(cp0_ex_t), .cp0_excode_t(cp0_excode_t), .cp0_bd(cp0_bd), .cp0_pc(cp0_pc),
    .cp0_badvaddr(cp0_badvaddr), .eret_flush(eret_flush), .cp0_we(cp0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .ws_flush(ws_flush),
    .inst_retired(inst_retired), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(logic [31:0] pc, logic bd, logic ex, logic [4:0] code,
                                logic [31:0] bva, logic eret, logic mtc0,
                                logic [4:0] a, logic [31:0] d);
    instr_t i;
    i.valid = 1'b1; i.pc = pc; i.bd = bd; i.ex = ex; i.excode = code; i.badvaddr = bva;
    i.eret = eret; i.mtc0 = mtc0; i.addr = a; i.wdata = d;
    return i;
  endfunction

  function automatic instr_t nop_i();
    instr_t i;
    i = mk(32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    i.valid = 1'b0;
    return i;
  endfunction

  task automatic drive(instr_t i, logic ack);
    ms_valid = i.valid; ms_pc = i.pc; ms_bd = i.bd; ms_ex = i.ex; ms_excode = i.excode;
    ms_badvaddr = i.badvaddr; ms_eret = i.eret; ms_mtc0 = i.mtc0;
    ms_cp0_addr = i.addr; ms_cp0_wdata = i.wdata; fs_refetch_ack = ack;
  endtask

  // Advance one clock, updating the model from the inputs currently applied.
  task automatic tick();
    logic   flush, normal, acc, n_int;
    instr_t cur;
    flush  = m_valid && (m_int || m_ws.ex || m_ws.eret);
    normal = m_valid && !flush;
    acc    = ms_valid && !m_drain && !flush;
    n_int  = cp0_status[0] && !cp0_status[1] && ((cp0_cause[15:8] & cp0_status[15:8]) != 8'h00);
    cur = mk(ms_pc, ms_bd, ms_ex, ms_excode, ms_badvaddr, ms_eret, ms_mtc0, ms_cp0_addr, ms_cp0_wdata);
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0; m_drain = 1'b0; m_int = 1'b0; m_ret = 32'd0;
      m_ws = mk(32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    end else begin
      if (normal) m_ret = m_ret + 32'd1;
      if (acc) m_ws = cur;
      m_valid = acc;
      m_drain = flush ? 1'b1 : (m_drain && !fs_refetch_ack);
      m_int   = n_int;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cp0_status = 32'd0; cp0_cause = 32'd0;
    drive(nop_i(), 1'b0);
    resetn = 1'b0; tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cp0_ex_t !== 1'b0 || eret_flush !== 1'b0 || cp0_we !== 1'b0 || ws_flush !== 1'b0) begin errors++; $display("FAIL reset_strobes: ex=%b eret=%b we=%b flush=%b, want all 0", cp0_ex_t, eret_flush, cp0_we, ws_flush); end
    checks++; if ({cp0_pc, cp0_badvaddr, cp0_wdata, cp0_addr, cp0_excode_t, cp0_bd} !== '0) begin errors++; $display("FAIL reset_data: pc=%h bva=%h wd=%h a=%h code=%h bd=%b, want 0", cp0_pc, cp0_badvaddr, cp0_wdata, cp0_addr, cp0_excode_t, cp0_bd); end
    checks++; if (inst_retired !== 32'd0 || fsm_state !== 1'b0 || ms_ready !== 1'b1) begin errors++; $display("FAIL reset_state: ret=%0d state=%b ready=%b, want 0 0 1", inst_retired, fsm_state, ms_ready); end
  endtask

  task automatic test_normal_stream();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(mk(32'hBFC00000 + 32'(4 * k), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0);
      tick();
      checks++; if ({cp0_ex_t, eret_flush, cp0_we, ws_flush} !== 4'b0) begin errors++; $display("FAIL stream_strobes[%0d]: got %b, want 0000", k, {cp0_ex_t, eret_flush, cp0_we, ws_flush}); end
      checks++; if (cp0_pc !== 32'hBFC00000 + 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, cp0_pc, 32'hBFC00000 + 32'(4 * k)); end
    end
    drive(nop_i(), 1'b0); tick();
    checks++; if (inst_retired !== 32'd5) begin errors++; $display("FAIL stream_retired: got %0d want 5", inst_retired); end
  endtask

  task automatic test_mtc0();
    do_reset();
    drive(mk(32'hBFC00020, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'h07, 32'h100), 1'b0);
    tick();
    checks++; if (cp0_we !== 1'b1 || cp0_addr !== 5'h07 || cp0_wdata !== 32'h100) begin errors++; $display("FAIL mtc0_write: we=%b addr=%h wdata=%h, want 1 07 100", cp0_we, cp0_addr, cp0_wdata); end
    checks++; if (cp0_ex_t !== 1'b0 || ws_flush !== 1'b0) begin errors++; $display("FAIL mtc0_noex: ex=%b flush=%b want 0 0", cp0_ex_t, ws_flush); end
    drive(nop_i(), 1'b0); tick();
    checks++; if (cp0_we !== 1'b0 || inst_retired !== 32'd1) begin errors++; $display("FAIL mtc0_single: we=%b ret=%0d want 0 1", cp0_we, inst_retired); end
  endtask

  task automatic test_adel();
    do_reset();
    drive(mk(32'hBFC00010, 1'b0, 1'b1, 5'h04, 32'h1, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0);
    tick();
    checks++; if (cp0_ex_t !== 1'b1 || cp0_excode_t !== 5'h04 || ws_flush !== 1'b1) begin errors++; $display("FAIL adel_strobe: ex=%b code=%h flush=%b want 1 04 1", cp0_ex_t, cp0_excode_t, ws_flush); end
    checks++; if (cp0_badvaddr !== 32'h1 || cp0_pc !== 32'hBFC00010) begin errors++; $display("FAIL adel_data: bva=%h pc=%h want 1 bfc00010", cp0_badvaddr, cp0_pc); end
    for (int k = 0; k < 3; k++) begin
      drive(mk(32'h8000_0000 + 32'(k), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'hDEAD), k == 2);
      tick();
      checks++; if ({cp0_ex_t, eret_flush, cp0_we, ws_flush} !== 4'b0) begin errors++; $display("FAIL adel_discard[%0d]: strobes %b want 0000", k, {cp0_ex_t, eret_flush, cp0_we, ws_flush}); end
      checks++; if (fsm_state !== (k != 2)) begin errors++; $display("FAIL adel_state[%0d]: got %b want %b", k, fsm_state, k != 2); end
    end
    drive(mk(32'hBFC00380, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd9, 32'h55), 1'b0);
    tick();
    checks++; if (cp0_we !== 1'b1 || cp0_pc !== 32'hBFC00380 || cp0_addr !== 5'd9) begin errors++; $display("FAIL adel_resume: we=%b pc=%h addr=%h want 1 bfc00380 09", cp0_we, cp0_pc, cp0_addr); end
    drive(nop_i(), 1'b0); tick();
    checks++; if (inst_retired !== 32'd1) begin errors++; $display("FAIL adel_retired: got %0d want 1", inst_retired); end
  endtask

  task automatic test_interrupt();
    do_reset();
    cp0_status = 32'h0000_8001; cp0_cause = 32'h0000_8000;
    tick(); tick();
    drive(mk(32'hBFC00040, 1'b1, 1'b1, 5'h0c, 32'd0, 1'b0, 1'b1, 5'h0c, 32'h1234), 1'b0);
    tick();
    checks++; if (cp0_ex_t !== 1'b1 || cp0_excode_t !== 5'h00 || ws_flush !== 1'b1) begin errors++; $display("FAIL int_strobe: ex=%b code=%h flush=%b want 1 00 1", cp0_ex_t, cp0_excode_t, ws_flush); end
    checks++; if (cp0_we !== 1'b0 || eret_flush !== 1'b0 || cp0_bd !== 1'b1) begin errors++; $display("FAIL int_suppress: we=%b eret=%b bd=%b want 0 0 1", cp0_we, eret_flush, cp0_bd); end
    cp0_status = 32'd0; cp0_cause = 32'd0;
    drive(nop_i(), 1'b1); tick();
    checks++; if (inst_retired !== 32'd0) begin errors++; $display("FAIL int_retired: got %0d want 0", inst_retired); end
  endtask

  task automatic test_eret();
    do_reset();
    drive(mk(32'hBFC00050, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0), 1'b0);
    tick();
    checks++; if (eret_flush !== 1'b1 || cp0_ex_t !== 1'b0 || ws_flush !== 1'b1) begin errors++; $display("FAIL eret_strobe: eret=%b ex=%b flush=%b want 1 0 1", eret_flush, cp0_ex_t, ws_flush); end
    drive(nop_i(), 1'b0); tick();
    checks++; if (fsm_state !== 1'b1) begin errors++; $display("FAIL eret_drain: state=%b want 1", fsm_state); end
    drive(nop_i(), 1'b1); tick();
    drive(nop_i(), 1'b0);
    cp0_status = 32'h0000_8003; cp0_cause = 32'h0000_8000;
    tick(); tick();
    drive(mk(32'hBFC00060, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0), 1'b0);
    tick();
    checks++; if (eret_flush !== 1'b1 || cp0_ex_t !== 1'b0) begin errors++; $display("FAIL eret_exl: eret=%b ex=%b want 1 0", eret_flush, cp0_ex_t); end
    cp0_status = 32'd0; cp0_cause = 32'd0;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.retired_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_q;
    m_ret = 32'hFFFF_FFFF;
    checks++; if (inst_retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", inst_retired); end
    drive(mk(32'hBFC00070, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0);
    tick();
    drive(nop_i(), 1'b0); tick();
    checks++; if (inst_retired !== 32'd0) begin errors++; $display("FAIL wrap_zero: got %h want 0", inst_retired); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    drive(mk(32'hBFC00080, 1'b0, 1'b1, 5'h08, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0);
    tick();
    drive(nop_i(), 1'b0); tick();
    checks++; if (fsm_state !== 1'b1) begin errors++; $display("FAIL rstdrain_enter: state=%b want 1", fsm_state); end
    resetn = 1'b0; tick();
    checks++; if (fsm_state !== 1'b0 || {cp0_ex_t, eret_flush, cp0_we, ws_flush} !== 4'b0 || {cp0_pc, cp0_excode_t, inst_retired} !== '0) begin errors++; $display("FAIL rstdrain_clear: state=%b pc=%h code=%h ret=%0d want 0", fsm_state, cp0_pc, cp0_excode_t, inst_retired); end
    resetn = 1'b1;
    drive(mk(32'hBFC00090, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0), 1'b0);
    tick();
    checks++; if (cp0_pc !== 32'hBFC00090 || ws_flush !== 1'b0) begin errors++; $display("FAIL rstdrain_run: pc=%h flush=%b want bfc00090 0", cp0_pc, ws_flush); end
  endtask

  task automatic test_random();
    logic       e_ex, e_eret, e_we;
    logic [4:0] e_code;
    instr_t     i;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      e_ex   = m_valid && (m_int || m_ws.ex);
      e_code = m_int ? 5'h00 : m_ws.excode;
      e_eret = m_valid && !m_int && !m_ws.ex && m_ws.eret;
      e_we   = m_valid && !m_int && !m_ws.ex && !m_ws.eret && m_ws.mtc0;
      checks++; if ({cp0_ex_t, eret_flush, cp0_we, ws_flush} !== {e_ex, e_eret, e_we, e_ex | e_eret}) begin errors++; $display("FAIL rnd_strobes@%0d: got %b want %b", c, {cp0_ex_t, eret_flush, cp0_we, ws_flush}, {e_ex, e_eret, e_we, e_ex | e_eret}); end
      checks++; if (inst_retired !== m_ret || fsm_state !== m_drain) begin errors++; $display("FAIL rnd_state@%0d: ret=%h state=%b want %h %b", c, inst_retired, fsm_state, m_ret, m_drain); end
      if (e_ex) begin
        checks++; if (cp0_excode_t !== e_code || cp0_badvaddr !== m_ws.badvaddr) begin errors++; $display("FAIL rnd_exc@%0d: code=%h bva=%h want %h %h", c, cp0_excode_t, cp0_badvaddr, e_code, m_ws.badvaddr); end
      end
      if (e_we) begin
        checks++; if (cp0_addr !== m_ws.addr || cp0_wdata !== m_ws.wdata) begin errors++; $display("FAIL rnd_mtc0@%0d: addr=%h wd=%h want %h %h", c, cp0_addr, cp0_wdata, m_ws.addr, m_ws.wdata); end
      end
      if (m_valid) begin
        checks++; if (cp0_pc !== m_ws.pc || cp0_bd !== m_ws.bd) begin errors++; $display("FAIL rnd_pc@%0d: pc=%h bd=%b want %h %b", c, cp0_pc, cp0_bd, m_ws.pc, m_ws.bd); end
      end
      i = mk($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 5'($urandom_range(4, 12)),
             $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, 5'($urandom), $urandom);
      i.valid = $urandom_range(0, 3) != 0;
      cp0_status = {16'd0, ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00, 6'd0, 1'($urandom_range(0, 1)), 1'b1};
      cp0_cause  = {16'd0, ($urandom_range(0, 5) == 0) ? 8'h80 : 8'h00, 8'd0};
      drive(i, $urandom_range(0, 3) == 0);
      tick();
    end
    cp0_status = 32'd0; cp0_cause = 32'd0;
  endtask

  initial begin
    resetn = 1'b0;
    cp0_status = 32'd0; cp0_cause = 32'd0;
    drive(nop_i(), 1'b0);
    @(negedge clk);
    test_reset();
    test_normal_stream();
    test_mtc0();
    test_adel();
    test_interrupt();
    test_eret();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
